// File: rtl/adc_frame_align_ctrl.sv
// Frame-lane word alignment sequencer: searches slip positions until the rotated frame word
// matches the expected pattern, publishes the slip count, and re-aligns on loss of lock.
module adc_frame_align_ctrl #(
    parameter int unsigned            DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0]  FRAME_PATTERN = 8'hF0,
    parameter int unsigned            SETTLE_CYCLES = 4,
    parameter int unsigned            MATCH_COUNT   = 16,
    parameter int unsigned            LOSS_COUNT    = 4
) (
    input  logic                  slow_clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] frame_word,
    output logic [3:0]            bitslip_count,
    output logic                  bitslip,
    output logic                  aligned,
    output logic                  align_fail,
    output logic                  busy,
    output logic [7:0]            loss_events
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned MW = $clog2(MATCH_COUNT + 1);
    localparam int unsigned LW = $clog2(LOSS_COUNT + 1);

    typedef enum logic [2:0] {
        StIdle, StSettle, StCheck, StSlip, StLocked, StFail
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
    logic [MW-1:0]   match_cnt_q, match_cnt_d;
    logic [LW-1:0]   miss_cnt_q, miss_cnt_d;
    logic [3:0]      slips_tried_q, slips_tried_d;
    logic [3:0]      slip_pos_q, slip_pos_d;
    logic [7:0]      loss_q, loss_d;
    logic            bitslip_q, bitslip_d;
    logic            aligned_q, aligned_d;
    logic            fail_q, fail_d;
    logic            busy_q, busy_d;

    logic [2*DATA_WIDTH-1:0] dbl_word;
    logic [DATA_WIDTH-1:0]   rot_word;
    logic                    match;

    // Rotate-left via a doubled word: the upper half of the shifted copy is the rotation.
    assign dbl_word = {frame_word, frame_word} << slip_pos_q;
    assign rot_word = dbl_word[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign match    = (rot_word == FRAME_PATTERN);

    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        match_cnt_d   = match_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        slips_tried_d = slips_tried_q;
        slip_pos_d    = slip_pos_q;
        loss_d        = loss_q;

        if (!ena) begin
            state_d = StIdle;
        end else if (start) begin
            state_d       = StSettle;
            settle_cnt_d  = '0;
            match_cnt_d   = '0;
            miss_cnt_d    = '0;
            slips_tried_d = '0;
            slip_pos_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StSettle: begin
                    if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                        state_d      = StCheck;
                        settle_cnt_d = '0;
                        match_cnt_d  = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SW'(1);
                    end
                end
                StCheck: begin
                    if (match) begin
                        if (match_cnt_q == MW'(MATCH_COUNT - 1)) begin
                            state_d    = StLocked;
                            miss_cnt_d = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + MW'(1);
                        end
                    end else if (slips_tried_q == 4'(DATA_WIDTH - 1)) begin
                        state_d = StFail;
                    end else begin
                        // The slip is committed on entry so count and pulse land together.
                        state_d       = StSlip;
                        slips_tried_d = slips_tried_q + 4'd1;
                        slip_pos_d    = (slip_pos_q == 4'(DATA_WIDTH - 1)) ? 4'd0
                                                                           : slip_pos_q + 4'd1;
                    end
                end
                StSlip: begin
                    state_d      = StSettle;
                    settle_cnt_d = '0;
                end
                StLocked: begin
                    if (match) begin
                        miss_cnt_d = '0;
                    end else if (miss_cnt_q == LW'(LOSS_COUNT - 1)) begin
                        state_d       = StSettle;
                        settle_cnt_d  = '0;
                        miss_cnt_d    = '0;
                        slips_tried_d = '0;
                        if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                    end else begin
                        miss_cnt_d = miss_cnt_q + LW'(1);
                    end
                end
                StFail: ;
                default: state_d = StIdle;
            endcase
        end

        bitslip_d = ena && (slip_pos_d != slip_pos_q);
        aligned_d = (state_d == StLocked);
        fail_d    = (state_d == StFail);
        busy_d    = (state_d == StSettle) || (state_d == StCheck) || (state_d == StSlip);
    end

    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            settle_cnt_q  <= '0;
            match_cnt_q   <= '0;
            miss_cnt_q    <= '0;
            slips_tried_q <= '0;
            slip_pos_q    <= '0;
            loss_q        <= '0;
            bitslip_q     <= 1'b0;
            aligned_q     <= 1'b0;
            fail_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            match_cnt_q   <= match_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            slips_tried_q <= slips_tried_d;
            slip_pos_q    <= slip_pos_d;
            loss_q        <= loss_d;
            bitslip_q     <= bitslip_d;
            aligned_q     <= aligned_d;
            fail_q        <= fail_d;
            busy_q        <= busy_d;
        end
    end

    assign bitslip_count = slip_pos_q;
    assign bitslip       = bitslip_q;
    assign aligned       = aligned_q;
    assign align_fail    = fail_q;
    assign busy          = busy_q;
    assign loss_events   = loss_q;

endmodule

// File: tb/tb_adc_frame_align_ctrl.sv
// Bench for adc_frame_align_ctrl: table of frame words with expected lock/fail results, a
// bitslip scoreboard, and hand-written sequences for loss of lock, reset and enable.
module tb_adc_frame_align_ctrl;

    logic       slow_clk = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic [7:0] frame_word = 8'hF0;
    logic [3:0] bitslip_count;
    logic       bitslip, aligned, align_fail, busy;
    logic [7:0] loss_events;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    adc_frame_align_ctrl dut (
        .slow_clk     (slow_clk),
        .reset        (reset),
        .ena          (ena),
        .start        (start),
        .frame_word   (frame_word),
        .bitslip_count(bitslip_count),
        .bitslip      (bitslip),
        .aligned      (aligned),
        .align_fail   (align_fail),
        .busy         (busy),
        .loss_events  (loss_events)
    );

    always #5 slow_clk = ~slow_clk;

    typedef struct {
        logic [7:0] frame;
        int         slips;
        logic [3:0] exp_count;
        logic       exp_fail;
        int         exp_edges;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge slow_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"}, 32'(bitslip_count), 32'd0);
        check({tag, "_bitslip"}, 32'(bitslip), 32'd0);
        check({tag, "_aligned"}, 32'(aligned), 32'd0);
        check({tag, "_fail"}, 32'(align_fail), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_loss"}, 32'(loss_events), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        ena   = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        check("reset_pending_slips", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Edges after the start/loss edge until aligned or align_fail rises.
    task automatic wait_done(output int n);
        n = 0;
        while (!(aligned || align_fail) && n < 300) begin
            tick();
            n++;
        end
    endtask

    // Scoreboard: every bitslip pulse must carry the next expected count.
    initial begin
        forever begin
            @(posedge slow_clk);
            #1;
            if (bitslip) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bitslip actual=count %0d required=no pulse",
                             bitslip_count);
                end else begin
                    check("bitslip_count_at_pulse", 32'(bitslip_count), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int n;

        // One slip costs SLIP + SETTLE + CHECK = 6 edges; lock needs 4 + 16 edges after the last.
        vecs[0] = '{frame: 8'hF0, slips: 0, exp_count: 4'd0, exp_fail: 1'b0, exp_edges: 20};
        vecs[1] = '{frame: 8'h1E, slips: 3, exp_count: 4'd3, exp_fail: 1'b0, exp_edges: 38};
        vecs[2] = '{frame: 8'h87, slips: 5, exp_count: 4'd5, exp_fail: 1'b0, exp_edges: 50};
        vecs[3] = '{frame: 8'hE1, slips: 7, exp_count: 4'd7, exp_fail: 1'b0, exp_edges: 62};
        vecs[4] = '{frame: 8'hAA, slips: 7, exp_count: 4'd7, exp_fail: 1'b1, exp_edges: 47};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            frame_word = vecs[v].frame;
            for (int i = 1; i <= vecs[v].slips; i++) exp_q.push_back(4'(i));
            pulse_start();
            wait_done(n);
            check("done_latency", 32'(n), 32'(vecs[v].exp_edges));
            check("final_count", 32'(bitslip_count), 32'(vecs[v].exp_count));
            check("final_aligned", 32'(aligned), 32'(!vecs[v].exp_fail));
            check("final_fail", 32'(align_fail), 32'(vecs[v].exp_fail));
            tick();
            check("pending_slips", 32'(exp_q.size()), 32'd0);
        end

        // Restart out of FAIL: count returns to 0 with one pulse, search begins again.
        exp_q.push_back(4'd0);
        pulse_start();
        check("restart_count", 32'(bitslip_count), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_fail", 32'(align_fail), 32'd0);

        // Lock at 3, then three misses and a good word must not lose lock.
        do_reset();
        frame_word = 8'h1E;
        for (int i = 1; i <= 3; i++) exp_q.push_back(4'(i));
        pulse_start();
        wait_done(n);
        check("lock3_aligned", 32'(aligned), 32'd1);
        for (int r = 0; r < 2; r++) begin
            frame_word = 8'h00;
            for (int i = 0; i < 3; i++) tick();
            frame_word = 8'h1E;
            tick();
            check("glitch_aligned", 32'(aligned), 32'd1);
            check("glitch_loss", 32'(loss_events), 32'd0);
        end

        // Four misses: aligned drops after the fourth, re-lock at 3 with no pulse.
        frame_word = 8'h00;
        for (int i = 0; i < 3; i++) tick();
        check("loss_pre_aligned", 32'(aligned), 32'd1);
        tick();
        check("loss_aligned", 32'(aligned), 32'd0);
        check("loss_events", 32'(loss_events), 32'd1);
        check("loss_busy", 32'(busy), 32'd1);
        frame_word = 8'h1E;
        wait_done(n);
        check("relock_latency", 32'(n), 32'd20);
        check("relock_count", 32'(bitslip_count), 32'd3);
        check("relock_aligned", 32'(aligned), 32'd1);
        tick();
        check("relock_pending", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while in SLIP.
        do_reset();
        frame_word = 8'hAA;
        exp_q.push_back(4'd1);
        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        check("slip_state_bitslip", 32'(bitslip), 32'd1);
        check("slip_state_count", 32'(bitslip_count), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_count", 32'(bitslip_count), 32'd0);

        // ena low during CHECK: IDLE, flags cleared, count held, start ignored.
        do_reset();
        frame_word = 8'h1E;
        exp_q.push_back(4'd1);
        pulse_start();
        for (int i = 0; i < 10; i++) tick();
        check("check_busy", 32'(busy), 32'd1);
        ena = 1'b0;
        tick();
        check("ena_busy", 32'(busy), 32'd0);
        check("ena_bitslip", 32'(bitslip), 32'd0);
        check("ena_aligned", 32'(aligned), 32'd0);
        check("ena_fail", 32'(align_fail), 32'd0);
        check("ena_count_held", 32'(bitslip_count), 32'd1);
        pulse_start();
        tick();
        check("ena_start_busy", 32'(busy), 32'd0);
        check("ena_start_count", 32'(bitslip_count), 32'd1);
        ena = 1'b1;
        tick();
        tick();
        check("ena_back_busy", 32'(busy), 32'd0);
        check("ena_pending", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
